// File: rtl/rsa_seq_pkg.sv
// Shared types and constants for the RSA operand loader / run sequencer.
package rsa_seq_pkg;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StCheck   = 4'd1,
        StKgStart = 4'd2,
        StKgWait  = 4'd3,
        StDnStart = 4'd4,
        StDnWait  = 4'd5,
        StExStart = 4'd6,
        StExWait  = 4'd7,
        StDone    = 4'd8,
        StErr     = 4'd9
    } state_e;

    localparam logic [1:0] SEL_P  = 2'b00;
    localparam logic [1:0] SEL_Q  = 2'b01;
    localparam logic [1:0] SEL_ML = 2'b10;
    localparam logic [1:0] SEL_MH = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OPERAND = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic is_busy(input state_e s);
        return s inside {StKgStart, StKgWait, StDnStart, StDnWait, StExStart, StExWait};
    endfunction

    function automatic logic is_start(input state_e s);
        return s inside {StKgStart, StDnStart, StExStart};
    endfunction

endpackage

// File: rtl/rsa_seq_ctrl_if.sv
// Host load bus plus RSA core handshake for rsa_seq_ctrl.
interface rsa_seq_ctrl_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic        go;
    logic        finish;
    logic        fin1;
    logic        finished;
    logic [7:0]  p;
    logic [7:0]  q;
    logic [15:0] M;
    logic        start;
    logic        start1;
    logic        start2;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] cycle_count;

    modport master (
        output in_byte, in_valid, in_sel, go, finish, fin1, finished,
        input  p, q, M, start, start1, start2, busy, done, error, err_code, cycle_count
    );

    modport slave (
        input  in_byte, in_valid, in_sel, go, finish, fin1, finished,
        output p, q, M, start, start1, start2, busy, done, error, err_code, cycle_count
    );
endinterface

// File: rtl/rsa_wait_timer.sv
// Saturating wait timer; expired_o flags that the count reaches TIMEOUT_CYCLES on this edge.
module rsa_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TW             = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TW:0] Limit = (TW + 1)'(TIMEOUT_CYCLES);

    logic [TW-1:0] count_q, count_d;
    logic [TW:0]   count_inc;

    always_comb begin
        count_inc = {1'b0, count_q} + (TW + 1)'(1);
        count_d   = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && ({1'b0, count_q} < Limit)) begin
            count_d = count_inc[TW-1:0];
        end
    end

    // Stays asserted once saturated, so a late WAIT still aborts.
    assign expired_o = en_i && (count_inc >= Limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rsa_seq_ctrl.sv
// Operand loader and keygen / d,n / modexp run sequencer for the RSA top level.
// Optional busy-cycle counter on cycle_count when RSA_SEQ_CYCLE_CNT_EN is defined.
module rsa_seq_ctrl
    import rsa_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TW             = 16
) (
    input logic           clk,
    input logic           rst,
    rsa_seq_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic [7:0]  p_q, p_d, q_q, q_d;
    logic [15:0] m_q, m_d;
    logic        start_q, start_d, start1_q, start1_d, start2_q, start2_d;
    logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        first_q, first_d;
    logic        operand_bad;
    logic        tmr_clear, tmr_en, tmr_expired;

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        q_d        = q_q;
        m_d        = m_q;
        err_code_d = err_code_q;

        if (bus.in_valid && !busy_q) begin
            unique case (bus.in_sel)
                SEL_P:  p_d        = bus.in_byte;
                SEL_Q:  q_d        = bus.in_byte;
                SEL_ML: m_d[7:0]   = bus.in_byte;
                SEL_MH: m_d[15:8]  = bus.in_byte;
            endcase
        end

        operand_bad = (p_q < 8'd2) || (q_q < 8'd2) || (p_q == q_q);

        // first_q masks a done level left high by the previous run.
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.go) begin
                    state_d    = StCheck;
                    err_code_d = ERR_NONE;
                end
            end
            StCheck: begin
                if (operand_bad) begin
                    state_d    = StErr;
                    err_code_d = ERR_OPERAND;
                end else begin
                    state_d = StKgStart;
                end
            end
            StKgStart: state_d = StKgWait;
            StDnStart: state_d = StDnWait;
            StExStart: state_d = StExWait;
            StKgWait: begin
                if (!first_q && bus.finish) state_d = StDnStart;
                else if (tmr_expired) begin
                    state_d    = StErr;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            StDnWait: begin
                if (!first_q && bus.fin1) state_d = StExStart;
                else if (tmr_expired) begin
                    state_d    = StErr;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            StExWait: begin
                if (!first_q && bus.finished) state_d = StDone;
                else if (tmr_expired) begin
                    state_d    = StErr;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            default: state_d = StIdle;
        endcase

        start_d  = (state_d == StKgStart);
        start1_d = (state_d == StDnStart);
        start2_d = (state_d == StExStart);
        busy_d   = is_busy(state_d);
        done_d   = (state_d == StDone);
        error_d  = (state_d == StErr);
        first_d  = is_start(state_q);
        // Clearing on entry lets the timer count the START cycle as elapsed time.
        tmr_clear = is_start(state_d);
        tmr_en    = busy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            p_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            start_q    <= 1'b0;
            start1_q   <= 1'b0;
            start2_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            q_q        <= q_d;
            m_q        <= m_d;
            start_q    <= start_d;
            start1_q   <= start1_d;
            start2_q   <= start2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            first_q    <= first_d;
        end
    end

    rsa_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TW            (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmr_clear),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

`ifdef RSA_SEQ_CYCLE_CNT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_d == StCheck) begin
            cyc_d = '0;
        end else if (busy_q && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.cycle_count = cyc_q;
`else
    assign bus.cycle_count = 16'd0;
`endif

    assign bus.p        = p_q;
    assign bus.q        = q_q;
    assign bus.M        = m_q;
    assign bus.start    = start_q;
    assign bus.start1   = start1_q;
    assign bus.start2   = start2_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Self-checking bench for rsa_seq_ctrl: directed scenarios plus randomized runs
// checked against an event-timeline model of the sequencer.
module tb_rsa_seq_ctrl;
    import rsa_seq_pkg::*;

    localparam int TO    = 20;
    localparam int NEVER = 100000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  mp = '0;
    logic [7:0]  mq = '0;
    logic [15:0] mm = '0;

    rsa_seq_ctrl_if bus ();

    rsa_seq_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .TW            (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic void model_write(input logic [1:0] sel, input logic [7:0] b);
        case (sel)
            SEL_P:   mp = b;
            SEL_Q:   mq = b;
            SEL_ML:  mm[7:0] = b;
            default: mm[15:8] = b;
        endcase
    endfunction

    task automatic load(input logic [1:0] sel, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_byte  = b;
        tick();
        bus.in_valid = 1'b0;
        model_write(sel, b);
    endtask

    // vis[ph] = cycles after a launch pulse at which the core's done level becomes
    // visible; 0 means it is already high before go, NEVER means it never rises.
    task automatic run(input string tag, input int v0, input int v1, input int v2,
                       input bit wr_go, input logic [1:0] wsel, input logic [7:0] wbyte,
                       input bit poke);
        int vis[3];
        int exp_t[3];
        int obs_t[3];
        int n_obs[3];
        int rise[3];
        int t0, t, t_end, obs_end, busy_n, onehot_bad, seen, exp_busy;
        bit valid, exp_done, ended, poked;
        logic [1:0] exp_code;
        logic [2:0] pulses;
        vis[0] = v0;
        vis[1] = v1;
        vis[2] = v2;
        for (int i = 0; i < 3; i++) begin
            exp_t[i] = -1;
            obs_t[i] = -1;
            n_obs[i] = 0;
            rise[i]  = -1;
        end
        bus.finish   = (v0 == 0);
        bus.fin1     = 1'b0;
        bus.finished = 1'b0;
        if (wr_go) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = wsel;
            bus.in_byte  = wbyte;
            model_write(wsel, wbyte);
        end
        bus.go = 1'b1;
        t0 = cyc;
        tick();
        bus.go       = 1'b0;
        bus.in_valid = 1'b0;

        // Expected timeline: start two cycles after go; each done level is honoured
        // no earlier than the second WAIT cycle; timer expiry lands ERR TO cycles
        // after the launch pulse, with done winning a tie.
        valid    = (mp >= 8'd2) && (mq >= 8'd2) && (mp != mq);
        exp_done = 1'b0;
        exp_code = ERR_OPERAND;
        t_end    = t0 + 2;
        if (valid) begin
            t        = t0 + 2;
            exp_done = 1'b1;
            exp_code = ERR_NONE;
            for (int ph = 0; ph < 3 && exp_done; ph++) begin
                exp_t[ph] = t;
                seen = (vis[ph] < 2) ? 2 : vis[ph];
                if (seen <= TO - 1) begin
                    t = t + seen + 1;
                end else begin
                    exp_done = 1'b0;
                    exp_code = ERR_TIMEOUT;
                    t = t + TO;
                end
            end
            t_end = t;
        end
        exp_busy = valid ? (t_end - exp_t[0]) : 0;

        ended = 1'b0;
        obs_end = -1;
        busy_n = 0;
        onehot_bad = 0;
        poked = 1'b0;
        for (int k = 0; k < 300 && !ended; k++) begin
            if (rise[0] == cyc) bus.finish = 1'b1;
            if (rise[1] == cyc) bus.fin1 = 1'b1;
            if (rise[2] == cyc) bus.finished = 1'b1;
            pulses = {bus.start2, bus.start1, bus.start};
            if ($countones(pulses) > 1) onehot_bad++;
            for (int ph = 0; ph < 3; ph++) begin
                if (pulses[ph]) begin
                    n_obs[ph]++;
                    if (obs_t[ph] < 0) obs_t[ph] = cyc;
                    if (vis[ph] > 0 && vis[ph] < NEVER) rise[ph] = cyc + vis[ph];
                end
            end
            if (bus.busy) busy_n++;
            bus.in_valid = 1'b0;
            bus.go       = 1'b0;
            if (poke && bus.busy && !poked) begin
                bus.in_valid = 1'b1;
                bus.in_sel   = SEL_P;
                bus.in_byte  = 8'hFF;
                bus.go       = 1'b1;
                poked        = 1'b1;
            end
            if (bus.done || bus.error) begin
                ended   = 1'b1;
                obs_end = cyc;
            end else begin
                tick();
            end
        end
        bus.in_valid = 1'b0;
        bus.go       = 1'b0;

        chk({tag, "/ended"}, 32'(ended), 32'd1);
        chk({tag, "/end_cycle"}, 32'(obs_end - t0), 32'(t_end - t0));
        chk({tag, "/done"}, 32'(bus.done), 32'(exp_done));
        chk({tag, "/error"}, 32'(bus.error), 32'(!exp_done));
        chk({tag, "/err_code"}, 32'(bus.err_code), 32'(exp_code));
        for (int ph = 0; ph < 3; ph++) begin
            chk($sformatf("%s/pulse%0d_n", tag, ph), 32'(n_obs[ph]), 32'(exp_t[ph] >= 0 ? 1 : 0));
            chk($sformatf("%s/pulse%0d_t", tag, ph), 32'(obs_t[ph] - t0),
                32'(exp_t[ph] >= 0 ? exp_t[ph] - t0 : -1 - t0));
        end
        chk({tag, "/onehot"}, 32'(onehot_bad), 32'd0);
        chk({tag, "/busy_cycles"}, 32'(busy_n), 32'(exp_busy));
`ifdef RSA_SEQ_CYCLE_CNT_EN
        chk({tag, "/cycle_count"}, 32'(bus.cycle_count), 32'(exp_busy));
`else
        chk({tag, "/cycle_count"}, 32'(bus.cycle_count), 32'd0);
`endif
        chk({tag, "/p"}, 32'(bus.p), 32'(mp));
        chk({tag, "/q"}, 32'(bus.q), 32'(mq));
        chk({tag, "/M"}, 32'(bus.M), 32'(mm));
    endtask

    initial begin
        int pulses_n;
        bit reached;
        bus.in_byte  = '0;
        bus.in_valid = 1'b0;
        bus.in_sel   = '0;
        bus.go       = 1'b0;
        bus.finish   = 1'b0;
        bus.fin1     = 1'b0;
        bus.finished = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst/ctrl_outs", 32'({bus.start, bus.start1, bus.start2, bus.busy, bus.done,
                                  bus.error, bus.err_code}), 32'd0);
        chk("rst/cycle_count", 32'(bus.cycle_count), 32'd0);
        chk("rst/pqm", 32'({bus.p, bus.q, bus.M}), 32'd0);
        rst = 1'b0;
        tick();

        // Nominal run, core latencies 5/7/9 cycles after each pulse has ended.
        load(SEL_P, 8'd61);
        load(SEL_Q, 8'd53);
        load(SEL_ML, 8'h41);
        load(SEL_MH, 8'h00);
        run("s1", 6, 8, 10, 1'b0, SEL_P, 8'h00, 1'b0);
`ifdef RSA_SEQ_CYCLE_CNT_EN
        chk("s1/cycle_count_27", 32'(bus.cycle_count), 32'd27);
`else
        chk("s1/cycle_count_27", 32'(bus.cycle_count), 32'd0);
`endif

        // p == q rejected; then q rewritten in the same cycle as go.
        load(SEL_P, 8'd7);
        load(SEL_Q, 8'd7);
        run("s2_bad", 3, 3, 3, 1'b0, SEL_P, 8'h00, 1'b0);
        run("s2_fix", 3, 3, 3, 1'b1, SEL_Q, 8'd11, 1'b0);

        // fin1 never arrives: timeout.
        run("s3_timeout", 2, NEVER, 2, 1'b0, SEL_P, 8'h00, 1'b0);

        // Stale finish before go, plus write/go attempts while busy.
        run("s4_stale", 0, 4, 4, 1'b0, SEL_P, 8'h00, 1'b1);

        // Done visible on the very cycle the timer expires, and one cycle later.
        run("s5_tie", 19, 2, 2, 1'b0, SEL_P, 8'h00, 1'b0);
        run("s6_late", 2, 2, 20, 1'b0, SEL_P, 8'h00, 1'b0);

        // Operand boundaries.
        load(SEL_P, 8'd1);
        run("s7_p1", 2, 2, 2, 1'b0, SEL_P, 8'h00, 1'b0);
        run("s7_p2", 2, 2, 2, 1'b1, SEL_P, 8'd2, 1'b0);

        for (int i = 0; i < 10; i++) begin
            load(SEL_P, 8'($urandom_range(0, 15)));
            load(SEL_Q, 8'($urandom_range(0, 15)));
            load(SEL_ML, 8'($urandom));
            load(SEL_MH, 8'($urandom));
            run($sformatf("rnd%0d", i), int'($urandom_range(0, 21)), int'($urandom_range(1, 21)),
                int'($urandom_range(1, 21)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of DN_WAIT.
        load(SEL_P, 8'd13);
        load(SEL_Q, 8'd17);
        load(SEL_ML, 8'h5A);
        bus.finish   = 1'b1;
        bus.fin1     = 1'b0;
        bus.finished = 1'b0;
        bus.go       = 1'b1;
        tick();
        bus.go  = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            if (bus.start1) reached = 1'b1;
            else tick();
        end
        chk("mid_rst/reach_dn", 32'(reached), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst/ctrl_outs", 32'({bus.start, bus.start1, bus.start2, bus.busy, bus.done,
                                      bus.error, bus.err_code}), 32'd0);
        chk("mid_rst/cycle_count", 32'(bus.cycle_count), 32'd0);
        chk("mid_rst/pqm", 32'({bus.p, bus.q, bus.M}), 32'd0);
        pulses_n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses_n += int'(bus.start) + int'(bus.start1) + int'(bus.start2);
        end
        chk("mid_rst/no_pulses", 32'(pulses_n), 32'd0);
        bus.finish = 1'b0;
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
